// File: rtl/stack_pkg.sv
// Shared stack definitions: operation codes, SP drive encodings and sequencer states.
// Used by stack_ctrl, the SP register and the decode stage.
package stack_pkg;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_PUSH    = 2'b01;
    localparam logic [1:0] OP_POP     = 2'b10;
    localparam logic [1:0] OP_LOAD_SP = 2'b11;

    localparam logic [1:0] SP_HOLD = 2'b00;
    localparam logic [1:0] SP_INC  = 2'b01;
    localparam logic [1:0] SP_DEC  = 2'b10;
    localparam logic [1:0] SP_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MEM  = 2'b01,
        ST_UPD  = 2'b10
    } state_e;

endpackage

// File: rtl/stack_bounds_chk.sv
// Full/empty compare of the SP value taken at the handshake against the stack window.
// Only instantiated when STACK_CTRL_BOUNDS_EN is defined.
module stack_bounds_chk #(
    parameter int unsigned       DATA_W      = 32,
    parameter logic [DATA_W-1:0] STACK_BASE  = '0,
    parameter int unsigned       STACK_DEPTH = 256
) (
    input  logic [DATA_W-1:0] sp,
    output logic              full,
    output logic              empty
);

    localparam logic [DATA_W-1:0] STACK_LIMIT = STACK_BASE + DATA_W'(STACK_DEPTH);

    assign full  = (sp >= STACK_LIMIT);
    assign empty = (sp <= STACK_BASE);

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop sequencer: performs the memory access at SP, then pulses SPDrive for one cycle.
// Define STACK_CTRL_BOUNDS_EN to compile in overflow/underflow rejection.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned       DATA_W      = 32,
    parameter logic [DATA_W-1:0] STACK_BASE  = '0,
    parameter int unsigned       STACK_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [DATA_W-1:0] op_data,
    input  logic [DATA_W-1:0] SPInput,
    output logic [1:0]        SPDrive,
    output logic [DATA_W-1:0] SPSet,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic              overflow,
    output logic              underflow
);

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] spset_q, spset_d;
    logic [DATA_W-1:0] pop_data_q, pop_data_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              full, empty;

`ifdef STACK_CTRL_BOUNDS_EN
    // Compared against SPInput directly: a rejected op must resolve in its handshake cycle.
    stack_bounds_chk #(
        .DATA_W     (DATA_W),
        .STACK_BASE (STACK_BASE),
        .STACK_DEPTH(STACK_DEPTH)
    ) u_bounds (
        .sp   (SPInput),
        .full (full),
        .empty(empty)
    );
`else
    assign full  = 1'b0;
    assign empty = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d    = state_q;
        op_d       = op_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        spset_d    = spset_q;
        pop_data_d = pop_data_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    op_d = op_code;
                    unique case (op_code)
                        OP_PUSH: begin
                            if (full) begin
                                ovf_d = 1'b1;
                            end else begin
                                state_d = ST_MEM;
                                we_d    = 1'b1;
                                addr_d  = SPInput;
                                wdata_d = op_data;
                            end
                        end
                        OP_POP: begin
                            if (empty) begin
                                unf_d = 1'b1;
                            end else begin
                                state_d = ST_MEM;
                                we_d    = 1'b0;
                                addr_d  = SPInput - DATA_W'(1);
                            end
                        end
                        OP_LOAD_SP: begin
                            state_d = ST_UPD;
                            spset_d = op_data;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_d = ST_UPD;
                    if (op_q == OP_POP) pop_data_d = mem_rdata;
                end
            end
            ST_UPD:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_NOP;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            spset_q    <= '0;
            pop_data_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q    <= state_d;
            op_q       <= op_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            spset_q    <= spset_d;
            pop_data_q <= pop_data_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_comb begin
        SPDrive = SP_HOLD;
        if (state_q == ST_UPD) begin
            unique case (op_q)
                OP_PUSH:    SPDrive = SP_INC;
                OP_POP:     SPDrive = SP_DEC;
                OP_LOAD_SP: SPDrive = SP_LOAD;
                default:    SPDrive = SP_HOLD;
            endcase
        end
    end

    // mem_req decodes straight from state so an async reset drops it immediately.
    assign op_ready  = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_MEM);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign SPSet     = spset_q;
    assign pop_valid = (state_q == ST_UPD) && (op_q == OP_POP);
    assign pop_data  = pop_data_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed table-driven bench for stack_ctrl with a behavioural SP register and memory.
// Expectations follow STACK_CTRL_BOUNDS_EN when the bench is built with it.
module tb_stack_ctrl;
    import stack_pkg::*;

`ifdef STACK_CTRL_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_code = 2'b00;
    logic [31:0] op_data = '0;
    logic [31:0] SPInput;
    logic [1:0]  SPDrive;
    logic [31:0] SPSet;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        pop_valid;
    logic [31:0] pop_data;
    logic        overflow, underflow;

    int n_vec  = 0;
    int n_miss = 0;

    logic [31:0] sp_model;
    logic [31:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    stack_ctrl dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_data(op_data),
        .SPInput(SPInput), .SPDrive(SPDrive), .SPSet(SPSet),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .pop_valid(pop_valid), .pop_data(pop_data),
        .overflow(overflow), .underflow(underflow)
    );

    // Behavioural SP register reacting to SPDrive/SPSet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sp_model <= '0;
        else begin
            case (SPDrive)
                SP_INC:  sp_model <= sp_model + 32'd1;
                SP_DEC:  sp_model <= sp_model - 32'd1;
                SP_LOAD: sp_model <= SPSet;
                default: sp_model <= sp_model;
            endcase
        end
    end
    assign SPInput = sp_model;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] data;
        int          delay;
        int          lat;
        bit          mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  drive;
        bit          popv;
        logic [31:0] pdata;
        logic [31:0] sp;
        bit          ovf;
        bit          unf;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_lookup(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a;
    endfunction

    function automatic vec_t mk(input logic [1:0] code, input logic [31:0] data, input int delay,
                                input int lat, input bit mem, input logic we, input logic [31:0] addr,
                                input logic [1:0] drive, input bit popv, input logic [31:0] pdata,
                                input logic [31:0] sp, input bit ovf, input bit unf);
        vec_t v;
        v.code = code; v.data = data; v.delay = delay; v.lat = lat; v.mem = mem; v.we = we;
        v.addr = addr; v.wdata = data; v.drive = drive; v.popv = popv; v.pdata = pdata;
        v.sp = sp; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic apply(input int idx, input vec_t v);
        int          lat = 0, n_drv = 0, n_pv = 0, req_cyc = 0;
        bit          seen_req = 0, done = 0;
        logic [31:0] a = '0, wd = '0, pd = '0;
        logic        w = 1'b0;
        logic [1:0]  drv = 2'b00;
        string       tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, ".ready_in"}, {31'd0, op_ready}, 32'd1);
        op_valid = 1'b1; op_code = v.code; op_data = v.data;
        @(negedge clk);
        op_valid = 1'b0; op_code = OP_NOP;
        for (int c = 1; c <= 20 && !done; c++) begin
            mem_ack = 1'b0;
            if (mem_req) begin
                if (!seen_req) begin
                    seen_req = 1; a = mem_addr; w = mem_we; wd = mem_wdata;
                end
                if (req_cyc == v.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_lookup(mem_addr);
                    if (mem_we) mem_model[mem_addr] = mem_wdata;
                end
                req_cyc++;
            end
            if (SPDrive != SP_HOLD) begin n_drv++; drv = SPDrive; end
            if (pop_valid) begin n_pv++; pd = pop_data; end
            if (op_ready) begin lat = c; done = 1; end
            else @(negedge clk);
        end
        mem_ack = 1'b0;
        check({tag, ".latency"}, lat, v.lat);
        check({tag, ".mem_req"}, {31'd0, seen_req}, {31'd0, v.mem});
        if (v.mem) begin
            check({tag, ".mem_addr"}, a, v.addr);
            check({tag, ".mem_we"}, {31'd0, w}, {31'd0, v.we});
            if (v.we) check({tag, ".mem_wdata"}, wd, v.wdata);
        end
        check({tag, ".drive_cycles"}, n_drv, (v.drive != SP_HOLD) ? 1 : 0);
        if (v.drive != SP_HOLD) check({tag, ".SPDrive"}, {30'd0, drv}, {30'd0, v.drive});
        if (v.code == OP_LOAD_SP) check({tag, ".SPSet"}, SPSet, v.data);
        check({tag, ".pop_valid_cycles"}, n_pv, v.popv ? 1 : 0);
        if (v.popv) check({tag, ".pop_data"}, pd, v.pdata);
        check({tag, ".sp"}, sp_model, v.sp);
        check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, v.ovf});
        check({tag, ".underflow"}, {31'd0, underflow}, {31'd0, v.unf});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back(mk(OP_PUSH, 32'd5791, 0, 3, 1, 1'b1, 32'd0, SP_INC, 0, 0, 32'd1, 0, 0));
        tbl.push_back(mk(OP_PUSH, 32'd7894, 0, 3, 1, 1'b1, 32'd1, SP_INC, 0, 0, 32'd2, 0, 0));
        tbl.push_back(mk(OP_POP, 32'd0, 2, 5, 1, 1'b0, 32'd1, SP_DEC, 1, 32'd7894, 32'd1, 0, 0));
        tbl.push_back(mk(OP_NOP, 32'd99, 0, 1, 0, 1'b0, 32'd0, SP_HOLD, 0, 0, 32'd1, 0, 0));
        tbl.push_back(mk(OP_LOAD_SP, 32'd255, 0, 2, 0, 1'b0, 32'd0, SP_LOAD, 0, 0, 32'd255, 0, 0));
        tbl.push_back(mk(OP_PUSH, 32'h0000_AAAA, 1, 4, 1, 1'b1, 32'd255, SP_INC, 0, 0, 32'd256, 0, 0));
        if (BOUNDS)
            tbl.push_back(mk(OP_PUSH, 32'h0000_BBBB, 0, 1, 0, 1'b0, 32'd0, SP_HOLD, 0, 0, 32'd256, 1, 0));
        else
            tbl.push_back(mk(OP_PUSH, 32'h0000_BBBB, 0, 3, 1, 1'b1, 32'd256, SP_INC, 0, 0, 32'd257, 0, 0));
        tbl.push_back(mk(OP_LOAD_SP, 32'd0, 0, 2, 0, 1'b0, 32'd0, SP_LOAD, 0, 0, 32'd0, BOUNDS, 0));
        if (BOUNDS)
            tbl.push_back(mk(OP_POP, 32'd0, 0, 1, 0, 1'b0, 32'd0, SP_HOLD, 0, 0, 32'd0, 1, 1));
        else
            tbl.push_back(mk(OP_POP, 32'd0, 0, 3, 1, 1'b0, 32'hFFFF_FFFF, SP_DEC, 1, 32'd0,
                             32'hFFFF_FFFF, 0, 0));
        tbl.push_back(mk(OP_LOAD_SP, 32'd2, 0, 2, 0, 1'b0, 32'd0, SP_LOAD, 0, 0, 32'd2, BOUNDS, BOUNDS));
        tbl.push_back(mk(OP_POP, 32'd0, 0, 3, 1, 1'b0, 32'd1, SP_DEC, 1, 32'd7894, 32'd1, BOUNDS, BOUNDS));
        tbl.push_back(mk(OP_PUSH, 32'h0000_1234, 3, 6, 1, 1'b1, 32'd1, SP_INC, 0, 0, 32'd2, BOUNDS, BOUNDS));

        // Reset values
        #12;
        check("rst.mem_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst.op_ready", {31'd0, op_ready}, 32'd1);
        check("rst.SPDrive", {30'd0, SPDrive}, 32'd0);
        check("rst.SPSet", SPSet, 32'd0);
        check("rst.mem_req", {31'd0, mem_req}, 32'd0);
        check("rst.mem_we", {31'd0, mem_we}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.mem_wdata", mem_wdata, 32'd0);
        check("rst.pop_valid", {31'd0, pop_valid}, 32'd0);
        check("rst.pop_data", pop_data, 32'd0);
        check("rst.flags", {30'd0, overflow, underflow}, 32'd0);

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // NOP held on op_valid: always ready, no activity
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_NOP; op_data = 32'hFFFF_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("nop.op_ready", {31'd0, op_ready}, 32'd1);
            check("nop.mem_req", {31'd0, mem_req}, 32'd0);
            check("nop.SPDrive", {30'd0, SPDrive}, 32'd0);
        end
        op_valid = 1'b0;
        check("nop.sp", sp_model, 32'd2);

        // Reset while waiting for mem_ack, then a late ack
        @(negedge clk);
        op_valid = 1'b1; op_code = OP_PUSH; op_data = 32'h0000_0077;
        @(negedge clk);
        op_valid = 1'b0; op_code = OP_NOP;
        @(negedge clk);
        check("abort.mem_req_before", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort.mem_req_async", {31'd0, mem_req}, 32'd0);
        check("abort.SPDrive", {30'd0, SPDrive}, 32'd0);
        check("abort.flags", {30'd0, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = 1'b0;
            check("abort.ready_after", {31'd0, op_ready}, 32'd1);
            check("abort.no_req", {31'd0, mem_req}, 32'd0);
            check("abort.no_drive", {30'd0, SPDrive}, 32'd0);
            check("abort.no_pop", {31'd0, pop_valid}, 32'd0);
        end
        check("abort.mem_addr", mem_addr, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
